// File: rtl/wptr_full_level.sv
`default_nettype none
// ============================================================================
//  Module   : wptr_full_level
//  Purpose  : Async FIFO write-side pointer with full, level, almost-full and
//             sticky overflow flags, all in the write clock domain.
//  Revision : 1.0 - initial release
// ============================================================================
module wptr_full_level #(
    parameter int ADDR_SIZE = 3
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_inc,
    input  logic [ADDR_SIZE:0]   rd_ptr_sync,
    input  logic [ADDR_SIZE:0]   afull_thresh,
    input  logic                 ovf_clr,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE:0]   wr_ptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   wr_level,
    output logic                 overflow
);

    localparam int c_AW = ADDR_SIZE;

    logic [c_AW:0] r_wbin;
    logic [c_AW:0] w_wbinnext;
    logic [c_AW:0] w_wgraynext;
    logic [c_AW:0] w_rbin;
    logic [c_AW:0] w_lvl_next;
    logic [c_AW:0] w_full_cmp;
    logic          w_accept;

    assign w_accept    = wr_inc & ~full;
    assign w_wbinnext  = r_wbin + {{c_AW{1'b0}}, w_accept};
    assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar i = 0; i <= c_AW; i++) begin : g_g2b
            assign w_rbin[i] = ^rd_ptr_sync[c_AW:i];
        end
    endgenerate

    assign w_lvl_next = w_wbinnext - w_rbin;
    assign w_full_cmp = {~rd_ptr_sync[c_AW:c_AW-1], rd_ptr_sync[c_AW-2:0]};
    assign wr_addr    = r_wbin[c_AW-1:0];

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_wbin      <= '0;
            wr_ptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            r_wbin      <= w_wbinnext;
            wr_ptr      <= w_wgraynext;
            full        <= (w_wgraynext == w_full_cmp);
            almost_full <= (w_lvl_next >= afull_thresh);
            wr_level    <= w_lvl_next;
            // Set has priority over clear so a same-cycle error is never lost.
            overflow    <= (overflow & ~ovf_clr) | (wr_inc & full);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wptr_full_level.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wptr_full_level
//  Purpose  : Self-checking bench for wptr_full_level (ADDR_SIZE = 3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wptr_full_level;

    localparam int c_AW = 3;

    logic            wr_clk = 1'b0;
    logic            wr_rst = 1'b1;
    logic            wr_inc = 1'b0;
    logic [c_AW:0]   rd_ptr_sync = '0;
    logic [c_AW:0]   afull_thresh = '0;
    logic            ovf_clr = 1'b0;
    logic [c_AW-1:0] wr_addr;
    logic [c_AW:0]   wr_ptr;
    logic            full;
    logic            almost_full;
    logic [c_AW:0]   wr_level;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    // Reference state: total accepted writes modulo 16 and derived flags.
    int   m_w    = 0;
    int   m_lvl  = 0;
    logic m_full = 1'b0;
    logic m_af   = 1'b0;
    logic m_ovf  = 1'b0;

    wptr_full_level #(.ADDR_SIZE(c_AW)) dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .wr_inc       (wr_inc),
        .rd_ptr_sync  (rd_ptr_sync),
        .afull_thresh (afull_thresh),
        .ovf_clr      (ovf_clr),
        .wr_addr      (wr_addr),
        .wr_ptr       (wr_ptr),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level),
        .overflow     (overflow)
    );

    always #5 wr_clk = ~wr_clk;

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs, advances the reference model, waits past the edge.
    task automatic step(input logic rst, input logic inc, input int rd,
                        input logic [3:0] th, input logic clr);
        wr_rst       = rst;
        wr_inc       = inc;
        rd_ptr_sync  = to_gray(rd);
        afull_thresh = th;
        ovf_clr      = clr;
        if (rst) begin
            m_w = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            m_ovf  = (m_ovf && !clr) || (inc && m_full);
            m_w    = (m_w + ((inc && !m_full) ? 1 : 0)) % 16;
            m_lvl  = (((m_w - rd) % 16) + 16) % 16;
            m_full = (m_lvl == 8);
            m_af   = (m_lvl >= int'(th));
        end
        @(posedge wr_clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".addr"},  int'(wr_addr),     m_w % 8);
        chk({tag, ".ptr"},   int'(wr_ptr),      int'(to_gray(m_w)));
        chk({tag, ".full"},  int'(full),        int'(m_full));
        chk({tag, ".afull"}, int'(almost_full), int'(m_af));
        chk({tag, ".level"}, int'(wr_level),    m_lvl);
        chk({tag, ".ovf"},   int'(overflow),    int'(m_ovf));
    endtask

    typedef struct {
        logic       rst;
        logic       inc;
        int         rd;
        logic [3:0] th;
        logic       clr;
        logic [2:0] addr;
        logic [3:0] ptr;
        logic       full;
        logic       af;
        logic [3:0] lvl;
        logic       ovf;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int rd;
        logic [3:0] th;

        // rst inc rd th clr | addr ptr full af lvl ovf
        tbl[0]  = '{1, 1, 4, 6, 0, 0, 4'b0000, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 4, 6, 0, 0, 4'b0000, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 6, 0, 1, 4'b0001, 0, 0, 1, 0};
        tbl[3]  = '{0, 1, 0, 6, 0, 2, 4'b0011, 0, 0, 2, 0};
        tbl[4]  = '{0, 1, 0, 6, 0, 3, 4'b0010, 0, 0, 3, 0};
        tbl[5]  = '{0, 1, 0, 6, 0, 4, 4'b0110, 0, 0, 4, 0};
        tbl[6]  = '{0, 1, 0, 6, 0, 5, 4'b0111, 0, 0, 5, 0};
        tbl[7]  = '{0, 1, 0, 6, 0, 6, 4'b0101, 0, 1, 6, 0};
        tbl[8]  = '{0, 1, 0, 6, 0, 7, 4'b0100, 0, 1, 7, 0};
        tbl[9]  = '{0, 1, 0, 6, 0, 0, 4'b1100, 1, 1, 8, 0};
        tbl[10] = '{0, 1, 0, 6, 0, 0, 4'b1100, 1, 1, 8, 1};
        tbl[11] = '{0, 1, 0, 6, 0, 0, 4'b1100, 1, 1, 8, 1};
        tbl[12] = '{0, 0, 0, 6, 1, 0, 4'b1100, 1, 1, 8, 0};
        tbl[13] = '{0, 1, 0, 6, 1, 0, 4'b1100, 1, 1, 8, 1};
        tbl[14] = '{0, 0, 4, 6, 1, 0, 4'b1100, 0, 0, 4, 0};
        tbl[15] = '{0, 1, 4, 6, 0, 1, 4'b1101, 0, 0, 5, 0};
        tbl[16] = '{0, 1, 4, 6, 0, 2, 4'b1111, 0, 1, 6, 0};
        tbl[17] = '{0, 1, 4, 6, 0, 3, 4'b1110, 0, 1, 7, 0};
        tbl[18] = '{0, 1, 4, 6, 0, 4, 4'b1010, 1, 1, 8, 0};

        repeat (2) @(posedge wr_clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, tbl[i].inc, tbl[i].rd, tbl[i].th, tbl[i].clr);
            chk($sformatf("tbl%0d.addr", i),  int'(wr_addr),     int'(tbl[i].addr));
            chk($sformatf("tbl%0d.ptr", i),   int'(wr_ptr),      int'(tbl[i].ptr));
            chk($sformatf("tbl%0d.full", i),  int'(full),        int'(tbl[i].full));
            chk($sformatf("tbl%0d.afull", i), int'(almost_full), int'(tbl[i].af));
            chk($sformatf("tbl%0d.level", i), int'(wr_level),    int'(tbl[i].lvl));
            chk($sformatf("tbl%0d.ovf", i),   int'(overflow),    int'(tbl[i].ovf));
        end

        // Threshold 0: almost_full on the first cycle after reset, even when empty.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("th0.afull", int'(almost_full), 1);
        chk("th0.level", int'(wr_level), 0);

        // Threshold 9 exceeds the depth: never asserts, even full and pushing.
        step(1, 0, 0, 9, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 9, 0);
            chk($sformatf("th9.afull%0d", i), int'(almost_full), 0);
        end
        chk("th9.full", int'(full), 1);
        chk("th9.level", int'(wr_level), 8);

        // Reset in the middle of a burst, then writing restarts at address 0.
        step(1, 0, 0, 6, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 6, 0);
        chk("mid.level_pre", int'(wr_level), 5);
        step(1, 1, 0, 6, 0);
        check_model("mid_rst");
        chk("mid.addr0", int'(wr_addr), 0);
        step(0, 1, 0, 6, 0);
        chk("mid.addr1", int'(wr_addr), 1);
        check_model("mid_resume");

        // Random traffic with lagging read progress; exercises wrap repeatedly.
        step(1, 0, 0, 6, 0);
        rd = 0;
        th = 4'd6;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ((cyc % 97) == 0) th = 4'($urandom_range(0, 10));
            if (m_lvl > 0 && $urandom_range(0, 99) < 40) rd = (rd + 1) % 16;
            if ($urandom_range(0, 499) == 0) begin
                rd = 0;
                step(1, 1'($urandom), 0, th, 0);
            end else begin
                step(0, 1'($urandom_range(0, 99) < 65), rd, th,
                     1'($urandom_range(0, 99) < 10));
            end
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wptr_full_level.md
Name: wptr_full_level

Overview:
Parametrised next-generation write-side pointer and flag block for the async FIFO, on the write clock domain.
- Generates the binary write address and the Gray write pointer sent to the read domain.
- Adds a full flag that does not depend on wr_inc, an occupancy level, a programmable almost-full flag and a sticky overflow error.
- Pairs with the read-side pointer block and the Gray pointer synchronisers.

Parameters:
- ADDR_SIZE, 3, address width (AW). FIFO depth is 2^AW. Legal range is 2..16.

Ports:
- wr_clk  input  1  write clock; all logic is on its rising edge.
- wr_rst  input  1  synchronous, active-high reset.
- wr_inc  input  1  write request; accepted only when full=0.
- rd_ptr_sync  input  AW+1  Gray read pointer, already synchronised into wr_clk.
- afull_thresh  input  AW+1  almost-full threshold in words; quasi-static.
- ovf_clr  input  1  clears the sticky overflow flag.
- wr_addr  output  AW  RAM write address.
- wr_ptr  output  AW+1  registered Gray write pointer.
- full  output  1  registered full flag.
- almost_full  output  1  registered flag; set when level >= afull_thresh.
- wr_level  output  AW+1  registered occupancy as seen from the write side, 0..2^AW.
- overflow  output  1  sticky error flag; set by a write attempted while full.

Behaviour:
- Reset (wr_rst=1 at a wr_clk edge): internal wbin, wr_ptr, full, almost_full, wr_level and overflow all become 0. All inputs are ignored during reset. Reset asserted mid-operation has the same effect at the next edge.
- accept = wr_inc & ~full.
- wbinnext = wbin + accept, computed modulo 2^(AW+1).
- wgraynext = (wbinnext >> 1) ^ wbinnext.
- Registered each edge:
  - wbin <= wbinnext
  - wr_ptr <= wgraynext
- wr_addr = wbin[AW-1:0], combinational from the register.
- rbin = Gray-to-binary of rd_ptr_sync, combinational: rbin[AW] = g[AW]; rbin[i] = rbin[i+1] ^ g[i].
- lvl_next = (wbinnext - rbin) modulo 2^(AW+1).
- Flag updates at each edge:
  - full <= (wgraynext == {~rd_ptr_sync[AW:AW-1], rd_ptr_sync[AW-2:0]}). The term is independent of wr_inc, so the flag stays full while no read advances.
  - wr_level <= lvl_next.
  - almost_full <= (lvl_next >= afull_thresh), unsigned compare. Threshold 0 gives 1 on every non-reset cycle. A threshold above 2^AW never asserts.
  - overflow <= (overflow & ~ovf_clr) | (wr_inc & full). When set and clear happen in the same cycle, set wins.
- Latency: every flag reflects the state after this edge's write, with 0 extra cycles.
  - Read progress is seen only through rd_ptr_sync, so level and flags are pessimistic (high) by the synchroniser lag. This is the intended behaviour.
- Write while full: no pointer change, no address change, overflow set.
- Wrap-around: wbin rolls from 2^(AW+1)-1 to 0. The MSB/Gray wrap needs no special handling, and full/level stay correct across the wrap.
- No combinational path from any input to any output except rd_ptr_sync -> nothing. All outputs are registered or derived from a register.

Test Plan (ADDR_SIZE=3, depth 8):
1. Reset: hold wr_rst=1 for 2 cycles with wr_inc=1 and rd_ptr_sync=4'b0110.
   - Expect all outputs 0 and wr_addr=0.
   - Release reset and send one write: wr_ptr=4'b0001, wr_level=2'd? No: with rd_ptr_sync=0110 (bin 4), the level is computed modulo 16 and equals 13. Use rd_ptr_sync=0 instead: wr_level=1.
2. Fill: rd_ptr_sync=0, wr_inc=1 for 8 cycles.
   - wr_addr runs 0..7.
   - wr_ptr runs 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
   - full=1 and wr_level=8 after the 8th edge. full=0 after the 7th edge.
3. Overflow: with the FIFO full, keep wr_inc=1 for 2 cycles.
   - wr_ptr stays 1100 and overflow=1.
   - Pulse ovf_clr alone: overflow=0.
   - Assert ovf_clr together with wr_inc while full: overflow=1.
4. Drain and wrap: set rd_ptr_sync=0110 (bin 4).
   - full drops next edge and wr_level=4.
   - Write 4 more words: wr_addr runs 0..3, wr_ptr reaches 1010 (bin 12), full=1 and wr_level=8.
   - Continue reads to rd=1000 (bin 15) and writes until wbin rolls 15 -> 0. full and level stay correct across the wrap.
5. almost_full: afull_thresh=6, rd_ptr_sync=0, write 1 word per cycle.
   - almost_full=0 after the 5th write and 1 after the 6th.
   - Set afull_thresh=0: almost_full=1 on the first non-reset cycle.
   - Set afull_thresh=9: almost_full never asserts.
6. Mid-operation reset: at level 5, assert wr_rst for 1 cycle together with wr_inc=1.
   - All outputs 0 next edge.
   - Writing resumes from wr_addr=0.
